frame_tx: RTL and testbench

FRAME_TX -- requirements
Module: frame_tx

---
 rtl/frame_tx_if.sv | 26 ++
 rtl/frame_tx.sv | 124 ++++++++++++
 tb/tb_frame_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_tx_if.sv
// Handshake bundle for frame_tx: start request, result-FIFO read port,
// UART byte stream and status pulses.
interface frame_tx_if;
    logic       start;
    logic [7:0] cmd;
    logic [3:0] len;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    // master: the framer itself; slave: requester, FIFO and UART side
    modport master (
        input  start, cmd, len, fifo_empty, fifo_data, tx_ready,
        output fifo_rd, tx_data, tx_valid, busy, done, err
    );
    modport slave (
        output start, cmd, len, fifo_empty, fifo_data, tx_ready,
        input  fifo_rd, tx_data, tx_valid, busy, done, err
    );
endinterface

// File: rtl/frame_tx.sv
// Frame transmitter: SOF, LEN(=len+1), cmd, len payload bytes popped from a
// result FIFO, EOF -- streamed over a valid/ready byte interface.
module frame_tx #(
    parameter logic [7:0] SOF         = 8'hFE,
    parameter logic [7:0] EOF         = 8'hEF,
    parameter int         MAX_PAYLOAD = 8
) (
    input  logic        clk,
    input  logic        rst,
    frame_tx_if.master  bus
);
    typedef enum logic [3:0] {
        IDLE, SEND_SOF, SEND_LEN, SEND_CMD, FETCH, WAIT_D, SEND_D, SEND_EOF, DONE
    } state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [3:0] len;
    } frame_req_t;

    localparam logic [3:0] MAX_LEN = 4'(MAX_PAYLOAD);

    state_t     state_q, state_d;
    frame_req_t req_q, req_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       vld_q, vld_d;
    logic       err_q, err_d;
    logic       rd;
    logic       xfer;
    logic       len_ok;

    assign xfer   = vld_q & bus.tx_ready;
    assign len_ok = (bus.len != 4'd0) && (bus.len <= MAX_LEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // The output byte register is loaded one state ahead, so tx_valid/tx_data
    // come straight from flops and only move on an accepted transfer.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        rd      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (len_ok) begin
                        req_d   = '{cmd: bus.cmd, len: bus.len};
                        cnt_d   = 4'd0;
                        data_d  = SOF;
                        vld_d   = 1'b1;
                        state_d = SEND_SOF;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND_SOF: if (xfer) begin
                data_d  = {4'd0, req_q.len} + 8'd1;
                state_d = SEND_LEN;
            end
            SEND_LEN: if (xfer) begin
                data_d  = req_q.cmd;
                state_d = SEND_CMD;
            end
            SEND_CMD: if (xfer) begin
                vld_d   = 1'b0;
                state_d = FETCH;
            end
            FETCH: if (!bus.fifo_empty) begin
                rd      = 1'b1;
                state_d = WAIT_D;
            end
            WAIT_D: begin
                data_d  = bus.fifo_data;
                vld_d   = 1'b1;
                state_d = SEND_D;
            end
            SEND_D: if (xfer) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q + 4'd1 == req_q.len) begin
                    data_d  = EOF;
                    state_d = SEND_EOF;
                end else begin
                    vld_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            SEND_EOF: if (xfer) begin
                vld_d   = 1'b0;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.fifo_rd  = rd;
    assign bus.tx_data  = data_q;
    assign bus.tx_valid = vld_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_frame_tx.sv
// Scoreboarded bench for frame_tx: expected bytes are queued when a frame is
// requested and popped as the DUT hands bytes to the UART side.
module tb_frame_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;

    frame_tx_if bus();

    frame_tx dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];
    bit         toggle = 1'b0;
    bit         rd_pend = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         done_cnt = 0;
    int         err_cnt = 0;
    bit         busy_seen = 1'b0;
    bit         vld_seen = 1'b0;
    logic [31:0] e;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // FIFO read latency and UART ready pattern
    always @(posedge clk) begin
        #1;
        if (rd_pend) begin
            if (fifo_q.size() != 0) bus.fifo_data = fifo_q.pop_front();
            rd_pend = 1'b0;
        end
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.tx_ready   = toggle ? ~bus.tx_ready : 1'b1;
    end

    // Byte monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                chk("hold_valid", bus.tx_valid, 1);
                chk("hold_data", bus.tx_data, prev_data);
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                e = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEAD;
                chk("tx_byte", bus.tx_data, e);
            end
            if (bus.fifo_rd) begin
                chk("rd_when_empty", bus.fifo_empty, 0);
                rd_pend = 1'b1;
            end
            if (bus.done)     done_cnt++;
            if (bus.err)      err_cnt++;
            if (bus.busy)     busy_seen = 1'b1;
            if (bus.tx_valid) vld_seen = 1'b1;
        end
    end

    task automatic load(input logic [7:0] c, input logic [3:0] l, input logic [7:0] base,
                        input bit to_fifo);
        logic [7:0] d;
        exp_q.push_back(8'hFE);
        exp_q.push_back({4'd0, l} + 8'd1);
        exp_q.push_back(c);
        for (int i = 0; i < int'(l); i++) begin
            d = base + 8'(i) * 8'h11;
            exp_q.push_back(d);
            if (to_fifo) fifo_q.push_back(d);
        end
        exp_q.push_back(8'hEF);
    endtask

    task automatic go(input logic [7:0] c, input logic [3:0] l);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cmd = c; bus.len = l;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Counts negedges from the cycle after acceptance up to the done pulse
    task automatic wait_done(output int n);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (bus.done) break;
        end
        chk("done_seen", bus.done, 1);
    endtask

    task automatic after_done();
        @(negedge clk);
        chk("busy_after_done", bus.busy, 0);
        chk("done_one_cycle", bus.done, 0);
        chk("done_count", done_cnt, 1);
        chk("bytes_left", exp_q.size(), 0);
        chk("fifo_left", fifo_q.size(), 0);
    endtask

    task automatic wait_cmd_sent();
        int k = 0;
        while (exp_q.size() > 3 && k < 100) begin
            @(posedge clk);
            k++;
        end
        chk("cmd_sent", exp_q.size(), 3);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_tx_valid"}, bus.tx_valid, 0);
        chk({tag, "_tx_data"}, bus.tx_data, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_fifo_rd"}, bus.fifo_rd, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        bus.start = 1'b0; bus.cmd = 8'h00; bus.len = 4'd0;
        bus.fifo_empty = 1'b1; bus.fifo_data = 8'h00; bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b1;

        // basic frame, ready always high, minimum frame time
        done_cnt = 0;
        load(8'h03, 4'd2, 8'h11, 1'b1);
        go(8'h03, 4'd2);
        wait_done(n);
        chk("frame_cycles_len2", n, 11);
        after_done();

        // ready toggling every cycle
        toggle = 1'b1; done_cnt = 0;
        load(8'h03, 4'd2, 8'h11, 1'b1);
        go(8'h03, 4'd2);
        wait_done(n);
        after_done();
        toggle = 1'b0;

        // FIFO empty for 5 cycles after the cmd byte
        done_cnt = 0;
        load(8'h03, 4'd2, 8'h11, 1'b0);
        go(8'h03, 4'd2);
        wait_cmd_sent();
        repeat (5) begin
            @(negedge clk);
            chk("stall_fifo_rd", bus.fifo_rd, 0);
            chk("stall_tx_valid", bus.tx_valid, 0);
        end
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        wait_done(n);
        after_done();

        // rejected lengths
        err_cnt = 0; busy_seen = 1'b0; vld_seen = 1'b0;
        go(8'h10, 4'd0);
        @(negedge clk); chk("err_len0", bus.err, 1);
        @(negedge clk); chk("err_len0_pulse", bus.err, 0);
        go(8'h10, 4'd9);
        @(negedge clk); chk("err_len9", bus.err, 1);
        repeat (3) @(negedge clk);
        chk("err_count", err_cnt, 2);
        chk("err_busy_seen", busy_seen, 0);
        chk("err_valid_seen", vld_seen, 0);

        // reset during SEND_D aborts the frame
        done_cnt = 0;
        load(8'h05, 4'd2, 8'hAA, 1'b1);
        go(8'h05, 4'd2);
        wait_cmd_sent();
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (bus.tx_valid) break;
        end
        chk("in_send_d", bus.tx_valid, 1);
        #2 rst = 1'b0;
        #1 chk_idle_outputs("abort");
        exp_q.delete(); fifo_q.delete(); rd_pend = 1'b0; prev_stall = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        load(8'h04, 4'd1, 8'hD0, 1'b1);
        go(8'h04, 4'd1);
        wait_done(n);
        chk("frame_cycles_len1", n, 8);
        after_done();

        // start held and cmd/len churned while busy
        done_cnt = 0; err_cnt = 0;
        load(8'h03, 4'd2, 8'h11, 1'b1);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cmd = 8'h03; bus.len = 4'd2;
        @(posedge clk);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (bus.done) break;
            bus.cmd = 8'($urandom);
            bus.len = 4'($urandom_range(0, 15));
        end
        chk("restart_done_seen", bus.done, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("restart_done_count", done_cnt, 1);
        chk("restart_err_count", err_cnt, 0);
        chk("restart_bytes_left", exp_q.size(), 0);
        chk("restart_idle", bus.busy, 0);

        // maximum payload
        done_cnt = 0;
        load(8'h5A, 4'd8, 8'h01, 1'b1);
        go(8'h5A, 4'd8);
        wait_done(n);
        chk("frame_cycles_len8", n, 29);
        after_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
